// File: rtl/wb_bram_burst_if.sv
// Wishbone B4 bus bundle for wb_bram_burst. Signal names follow the original
// bus ports. The master modport drives requests and the slave modport returns data and ack.
interface wb_bram_burst_if #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADR_WIDTH-1:0]    adr;
  logic [DATA_WIDTH-1:0]   dat_m;
  logic [DATA_WIDTH-1:0]   dat_s;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport slave (
    input  adr, dat_m, sel, cyc, stb, we, cti, bte,
    output dat_s, ack, err, rty
  );

  modport master (
    output adr, dat_m, sel, cyc, stb, we, cti, bte,
    input  dat_s, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with registered-feedback incrementing bursts.
// Define WB_BRAM_WRAP_BURST_EN to honour bte wrap-4/8/16. Without it, every burst is linear.
module wb_bram_burst #(
  parameter int MEM_ADR_WIDTH = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int ADR_WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_bram_burst_if.slave   bus
);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(SEL_W);
  localparam int DEPTH = 1 << MEM_ADR_WIDTH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLASSIC = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [1:0]               state_q, state_d;
  logic [MEM_ADR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]    dat_s_q;

  logic [MEM_ADR_WIDTH-1:0] adr_word;
  logic [MEM_ADR_WIDTH-1:0] ptr_nxt;
  logic [MEM_ADR_WIDTH-1:0] rd_idx;
  logic                     req;
  logic                     rd_load;
  logic                     wr_en;
  logic                     ack;
  logic                     unused_bits;

  assign adr_word    = bus.adr[MEM_ADR_WIDTH+LSB-1:LSB];
  assign req         = bus.cyc & bus.stb;
  assign unused_bits = &{1'b0, bus.adr, bus.bte};

`ifdef WB_BRAM_WRAP_BURST_EN
  // Wrap bursts increment only the low bits. The upper bits keep the block base.
  always_comb begin
    ptr_nxt = ptr_q + MEM_ADR_WIDTH'(1);
    case (bus.bte)
      2'b01:   ptr_nxt = {ptr_q[MEM_ADR_WIDTH-1:2], ptr_q[1:0] + 2'd1};
      2'b10:   ptr_nxt = {ptr_q[MEM_ADR_WIDTH-1:3], ptr_q[2:0] + 3'd1};
      2'b11:   ptr_nxt = {ptr_q[MEM_ADR_WIDTH-1:4], ptr_q[3:0] + 4'd1};
      default: ptr_nxt = ptr_q + MEM_ADR_WIDTH'(1);
    endcase
  end
`else
  always_comb ptr_nxt = ptr_q + MEM_ADR_WIDTH'(1);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rd_load = 1'b0;
    rd_idx  = adr_word;
    wr_en   = 1'b0;
    ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          rd_load = 1'b1;
          if (bus.cti == CTI_INCR) begin
            ptr_d   = adr_word;
            state_d = BURST;
          end else begin
            state_d = CLASSIC;
          end
        end
      end
      CLASSIC: begin
        ack     = 1'b1;
        wr_en   = bus.we;
        state_d = IDLE;
      end
      BURST: begin
        if (!bus.cyc) begin
          state_d = IDLE;
        end else if (bus.stb) begin
          ack = 1'b1;
          if (bus.we) begin
            wr_en = 1'b1;
          end else begin
            // Prefetch the following word so the next beat can be acked on the next clock.
            rd_load = 1'b1;
            rd_idx  = ptr_nxt;
            ptr_d   = ptr_nxt;
          end
          if (bus.cti == CTI_END || bus.cti == CTI_CLASSIC) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dat_s_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (rd_load) dat_s_q <= mem_q[rd_idx];
    end
  end

  // RAM contents are not reset. Write enable comes from the reset-cleared FSM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < SEL_W; i++) begin
        if (bus.sel[i]) mem_q[adr_word][8*i +: 8] <= bus.dat_m[8*i +: 8];
      end
    end
  end

  assign bus.dat_s = dat_s_q;
  assign bus.ack   = ack;
  assign bus.err   = 1'b0;
  assign bus.rty   = 1'b0;
endmodule

// File: tb/tb_wb_bram_burst.sv
// Randomised self-checking bench for wb_bram_burst against a word-array model
// with the bus protocol computed per beat.
module tb_wb_bram_burst;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_bram_burst_if #(.ADR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  wb_bram_burst #(.MEM_ADR_WIDTH(11), .DATA_WIDTH(32), .ADR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem_m [DEPTH];
  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  logic exp_ack = 1'b0;
  logic exp_cd  = 1'b0;
  logic [31:0] exp_dat = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (bus.ack !== exp_ack) begin
        bad++;
        $display("FAIL ack t=%0t got=%b want=%b", $time, bus.ack, exp_ack);
      end
      if (exp_cd) begin
        total++;
        if (bus.dat_s !== exp_dat) begin
          bad++;
          $display("FAIL dat_s t=%0t got=%h want=%h", $time, bus.dat_s, exp_dat);
        end
      end
      total++;
      if (bus.err !== 1'b0 || bus.rty !== 1'b0) begin
        bad++;
        $display("FAIL err_rty t=%0t got=%b%b want=00", $time, bus.err, bus.rty);
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int nxt(input int p, input int bte);
    int n;
`ifdef WB_BRAM_WRAP_BURST_EN
    if (bte != 0) begin
      n = 4 << (bte - 1);
      return (p / n) * n + ((p % n) + 1) % n;
    end
`endif
    n = bte;
    return (p + 1) % DEPTH;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_(input logic a, input logic cd, input logic [31:0] d);
    exp_ack = a;
    exp_cd  = cd;
    exp_dat = d;
  endtask

  task automatic bus_idle();
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    bus.cti = 3'b000;
  endtask

  task automatic classic(input bit w, input int word, input logic [31:0] d, input logic [3:0] s,
                         input bit use_lit, input logic [31:0] lit);
    logic [31:0] old_w;
    old_w = mem_m[word];
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.cti = 3'b000; bus.bte = 2'b00;
    bus.adr = 32'(word) << 2; bus.dat_m = d; bus.sel = s;
    expect_(1'b0, 1'b0, '0);
    step();
    expect_(1'b1, !w, use_lit ? lit : old_w);
    step();
    if (w) mem_m[word] = merge(old_w, d, s);
    bus_idle();
    expect_(1'b0, 1'b1, use_lit && !w ? lit : old_w);
    step();
  endtask

  task automatic burst(input bit w, input int start, input int len, input int bte,
                       input bit rnd_waits, input int wait_at, input bit end000, input bit full_sel);
    int p;
    logic [31:0] d;
    logic [3:0] s;
    p = start;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.cti = 3'b010; bus.bte = 2'(bte);
    bus.adr = 32'(p) << 2; bus.dat_m = $urandom; bus.sel = 4'hF;
    expect_(1'b0, 1'b0, '0);
    step();
    for (int k = 0; k < len; k++) begin
      if (k == wait_at || (rnd_waits && $urandom_range(0, 3) == 0)) begin
        for (int j = 0; j < 2; j++) begin
          bus.stb = 1'b0;
          expect_(1'b0, !w, mem_m[p]);
          step();
        end
      end
      d = $urandom;
      s = full_sel ? 4'hF : 4'($urandom_range(0, 15));
      bus.stb = 1'b1; bus.adr = 32'(p) << 2; bus.dat_m = d; bus.sel = s;
      bus.cti = (k == len - 1) ? (end000 ? 3'b000 : 3'b111) : 3'b010;
      expect_(1'b1, !w, mem_m[p]);
      step();
      if (w) mem_m[p] = merge(mem_m[p], d, s);
      p = nxt(p, bte);
    end
    bus_idle();
    expect_(1'b0, !w, mem_m[p]);
    step();
  endtask

  initial begin
    int ord [4];
    bus_idle();
    bus.adr = '0; bus.dat_m = '0; bus.sel = '0; bus.bte = '0;
    chk_en = 1'b1;
    expect_(1'b0, 1'b1, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    burst(1'b1, 0, DEPTH, 0, 1'b0, -1, 1'b0, 1'b1);

    classic(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, '0);
    classic(1'b0, 5, '0, 4'hF, 1'b1, 32'hDEADBEEF);
    classic(1'b1, 5, 32'h11223344, 4'b0101, 1'b0, '0);
    classic(1'b0, 5, '0, 4'h0, 1'b1, 32'hDE22BE44);

    classic(1'b1, 2047, 32'hCAFE07FF, 4'hF, 1'b0, '0);
    classic(1'b1, 0, 32'h0000CAFE, 4'hF, 1'b0, '0);
    burst(1'b0, 2044, 8, 0, 1'b0, 3, 1'b0, 1'b0);

    for (int w = 4; w < 10; w++) classic(1'b1, w, 32'hA0000000 + 32'(w), 4'hF, 1'b0, '0);
`ifdef WB_BRAM_WRAP_BURST_EN
    ord = '{6, 7, 4, 5};
`else
    ord = '{6, 7, 8, 9};
`endif
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.cti = 3'b010; bus.bte = 2'b01;
    bus.adr = 32'd6 << 2;
    expect_(1'b0, 1'b0, '0);
    step();
    for (int k = 0; k < 4; k++) begin
      bus.cti = (k == 3) ? 3'b111 : 3'b010;
      expect_(1'b1, 1'b1, 32'hA0000000 + 32'(ord[k]));
      step();
    end
    bus_idle();
    expect_(1'b0, 1'b0, '0);
    step();

    // Write burst abandoned by dropping cyc on the third beat.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.cti = 3'b010; bus.bte = 2'b00;
    bus.adr = 32'd100 << 2; bus.sel = 4'hF; bus.dat_m = 32'h600D0100;
    expect_(1'b0, 1'b0, '0);
    step();
    for (int k = 0; k < 2; k++) begin
      bus.adr = 32'(100 + k) << 2; bus.dat_m = 32'h600D0100 + 32'(k);
      expect_(1'b1, 1'b0, '0);
      step();
      mem_m[100 + k] = 32'h600D0100 + 32'(k);
    end
    bus.cyc = 1'b0; bus.adr = 32'd102 << 2; bus.dat_m = 32'h0BADBEEF;
    expect_(1'b0, 1'b0, '0);
    step();
    bus_idle();
    step();
    classic(1'b0, 100, '0, 4'hF, 1'b1, 32'h600D0100);
    classic(1'b0, 101, '0, 4'hF, 1'b1, 32'h600D0101);
    classic(1'b0, 102, '0, 4'hF, 1'b0, '0);

    // Reset in the middle of a read burst and in the middle of a write burst.
    for (int w = 0; w < 2; w++) begin
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'(w); bus.cti = 3'b010; bus.bte = 2'b00;
      bus.adr = 32'd10 << 2; bus.sel = 4'hF; bus.dat_m = ~mem_m[10];
      expect_(1'b0, 1'b0, '0);
      step();
      if (w == 0) begin
        expect_(1'b1, 1'b1, mem_m[10]);
        step();
      end
      rst_n = 1'b0;
      expect_(1'b0, 1'b1, '0);
      step(); step();
      rst_n = 1'b1;
      bus_idle();
      step();
      classic(1'b0, 10, '0, 4'hF, 1'b0, '0);
    end

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: classic(1'b1, $urandom_range(0, DEPTH - 1), $urandom, 4'($urandom_range(0, 15)), 1'b0, '0);
        1: classic(1'b0, $urandom_range(0, DEPTH - 1), '0, 4'($urandom_range(0, 15)), 1'b0, '0);
        2: burst(1'b1, $urandom_range(0, DEPTH - 1), $urandom_range(1, 8), $urandom_range(0, 3),
                 1'b1, -1, 1'($urandom_range(0, 1)), 1'b0);
        default: burst(1'b0, $urandom_range(0, DEPTH - 1), $urandom_range(1, 8), $urandom_range(0, 3),
                       1'b1, -1, 1'($urandom_range(0, 1)), 1'b0);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        expect_(1'b0, 1'b0, '0);
        step();
      end
    end
    for (int w = 0; w < 16; w++) classic(1'b0, $urandom_range(0, DEPTH - 1), '0, 4'hF, 1'b0, '0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
